// File: rtl/ps2_receiver.sv
// PS/2 device-frame receiver: synchronises the raw pad signals, deserialises
// 11-bit frames into scan codes and buffers them in a small FIFO.
module ps2_receiver #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000,
  parameter int TO_W       = 16
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Odd parity over data plus parity bit: the set-bit count must be odd.
  function automatic logic parity_odd_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  logic [2:0]      clk_sync_r;
  logic [1:0]      dat_sync_r;
  logic [3:0]      cnt_r;
  logic [9:0]      shift_r;
  logic [TO_W-1:0] to_cnt_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW:0]     wp_r;
  logic [AW:0]     rp_r;
  logic [7:0]      data_r;
  logic            overflow_r;
  logic            frame_err_r;

  logic            fall_s;
  logic            bit_s;
  logic            frame_end_s;
  logic            good_s;
  logic            bad_s;
  logic            timeout_s;
  logic            empty_s;
  logic            full_s;
  logic            pop_s;
  logic            push_s;
  logic            drop_s;
  logic [AW:0]     rp_next_s;
  logic [7:0]      head_next_s;

  // Frame decode, FIFO status and next head value.
  always_comb begin
    fall_s      = clk_sync_r[2] & ~clk_sync_r[1];
    bit_s       = dat_sync_r[1];
    frame_end_s = fall_s && (cnt_r == 4'd10);
    good_s      = frame_end_s && (shift_r[0] == 1'b0) && bit_s &&
                  parity_odd_ok(shift_r[9:1]);
    bad_s       = frame_end_s && !good_s;
    timeout_s   = !fall_s && (cnt_r != 4'd0) && (to_cnt_r == TO_W'(TIMEOUT));

    empty_s = (wp_r == rp_r);
    full_s  = (wp_r[AW] != rp_r[AW]) && (wp_r[AW-1:0] == rp_r[AW-1:0]);
    pop_s   = !nextdata_n && !empty_s;
    push_s  = good_s && (!full_s || pop_s);
    drop_s  = good_s && full_s && !pop_s;

    if (pop_s) begin
      rp_next_s = rp_r + {{AW{1'b0}}, 1'b1};
    end else begin
      rp_next_s = rp_r;
    end

    // A push into the slot that becomes the head must bypass the memory.
    if (push_s && (wp_r[AW-1:0] == rp_next_s[AW-1:0])) begin
      head_next_s = shift_r[8:1];
    end else begin
      head_next_s = mem_r[rp_next_s[AW-1:0]];
    end
  end

  // Pad synchronisers; idle line level is high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_r <= 3'b111;
      dat_sync_r <= 2'b11;
    end else begin
      clk_sync_r <= {clk_sync_r[1:0], ps2_clk};
      dat_sync_r <= {dat_sync_r[0], ps2_data};
    end
  end

  // Bit counter and shift register; a timeout abandons the partial frame.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_r   <= 4'd0;
      shift_r <= 10'd0;
    end else if (fall_s) begin
      if (cnt_r == 4'd10) begin
        cnt_r <= 4'd0;
      end else begin
        shift_r[cnt_r] <= bit_s;
        cnt_r          <= cnt_r + 4'd1;
      end
    end else if (timeout_s) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Inactivity counter, only running while a frame is in progress.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (fall_s || timeout_s) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (cnt_r != 4'd0) begin
      to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wp_r <= {(AW+1){1'b0}};
      rp_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wp_r[AW-1:0]] <= shift_r[8:1];
        wp_r                <= wp_r + {{AW{1'b0}}, 1'b1};
      end
      rp_r <= rp_next_s;
    end
  end

  // Registered head, sticky overflow and error pulse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data_r      <= 8'h00;
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      data_r      <= head_next_s;
      overflow_r  <= overflow_r | drop_s;
      frame_err_r <= bad_s | timeout_s;
    end
  end

  assign data      = data_r;
  assign ready     = ~empty_s;
  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: table of single frames plus hand-written
// sequences for latency, overflow, timeout and mid-frame reset.
module tb_ps2_receiver;

  localparam int DEPTH = 8;
  localparam int TOUT  = 200;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  ps2_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TOUT), .TO_W(16)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  typedef struct {
    logic [7:0] code;
    logic       par_ok;
    logic       stop_ok;
    logic       exp_ready;
    logic [7:0] exp_data;
    int         exp_err;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pop1();
    nextdata_n = 1'b0;
    tick(1);
    nextdata_n = 1'b1;
  endtask

  // mode 0: plain, 1: pop in the push cycle, 2: check push latency
  task automatic send_frame(input logic [7:0] d, input logic par_ok,
                            input logic stop_ok, input int mode);
    logic [10:0] bits;
    bits = {stop_ok, (par_ok ? ~(^d) : (^d)), d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      tick(4);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        tick(2);
        nextdata_n = 1'b0;
        tick(1);
        nextdata_n = 1'b1;
        tick(1);
      end else if (i == 10 && mode == 2) begin
        tick(2);
        chk("latency_not_yet", {31'd0, ready}, 32'd0);
        tick(1);
        chk("latency_ready", {31'd0, ready}, 32'd1);
        chk("latency_data", {24'd0, data}, {24'd0, d});
        tick(1);
      end else begin
        tick(4);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(4);
  endtask

  task automatic send_partial(input int nbits, input logic [10:0] bits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(4);
      ps2_clk = 1'b0;
      tick(4);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    vec_t vecs [8];
    int   base;
    logic [10:0] part;

    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b1, 8'h1C, 0};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 0};
    vecs[2] = '{8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 0};
    vecs[6] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    vecs[7] = '{8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1};

    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    tick(3);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    clrn = 1'b1;
    tick(2);

    // Test 1: latency, then a single pop empties the FIFO
    send_frame(8'h1C, 1'b1, 1'b1, 2);
    pop1();
    chk("t1_ready_after_pop", {31'd0, ready}, 32'd0);

    // Table of single frames
    for (int v = 0; v < 8; v++) begin
      base = err_pulses;
      send_frame(vecs[v].code, vecs[v].par_ok, vecs[v].stop_ok, 0);
      chk($sformatf("vec%0d_ready", v), {31'd0, ready}, {31'd0, vecs[v].exp_ready});
      if (vecs[v].exp_ready) begin
        chk($sformatf("vec%0d_data", v), {24'd0, data}, {24'd0, vecs[v].exp_data});
        pop1();
        chk($sformatf("vec%0d_drained", v), {31'd0, ready}, 32'd0);
      end
      chk($sformatf("vec%0d_err", v), err_pulses - base, vecs[v].exp_err);
    end

    // Test 2: ordering with the break prefix
    send_frame(8'hF0, 1'b1, 1'b1, 0);
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    tick(3);
    chk("t2_head_held", {24'd0, data}, 32'hF0);
    pop1();
    chk("t2_second", {24'd0, data}, 32'h1C);
    pop1();
    chk("t2_empty", {31'd0, ready}, 32'd0);
    pop1();
    chk("t2_pop_empty_ignored", {31'd0, ready}, 32'd0);

    // Test 4a: overflow on the ninth frame
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b1, 1'b1, 0);
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("t4_drain%0d", i), {24'd0, data}, i);
      pop1();
    end
    chk("t4_empty", {31'd0, ready}, 32'd0);
    chk("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Test 4b: push and pop together on a full FIFO
    clrn = 1'b0; tick(1); clrn = 1'b1; tick(1);
    for (int i = 1; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1'b1, 0);
    send_frame(8'h09, 1'b1, 1'b1, 1);
    chk("t4b_no_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 2; i <= DEPTH + 1; i++) begin
      chk($sformatf("t4b_drain%0d", i), {24'd0, data}, i);
      pop1();
    end
    chk("t4b_empty", {31'd0, ready}, 32'd0);

    // Test 5: timeout after a partial frame
    base = err_pulses;
    part = 11'b000_1010_0110;
    send_partial(5, part);
    tick(TOUT - 20);
    chk("t5_no_early_timeout", err_pulses - base, 0);
    tick(40);
    chk("t5_timeout_pulse", err_pulses - base, 1);
    send_frame(8'h29, 1'b1, 1'b1, 0);
    chk("t5_ready", {31'd0, ready}, 32'd1);
    chk("t5_data", {24'd0, data}, 32'h29);
    chk("t5_no_extra_err", err_pulses - base, 1);
    pop1();

    // Test 6: reset mid-frame with entries buffered
    send_frame(8'h11, 1'b1, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    send_frame(8'h33, 1'b1, 1'b1, 0);
    part = 11'b111_1111_0010;
    send_partial(3, part);
    clrn = 1'b0;
    #1;
    chk("t6_ready_async", {31'd0, ready}, 32'd0);
    chk("t6_overflow_async", {31'd0, overflow}, 32'd0);
    chk("t6_data_async", {24'd0, data}, 32'd0);
    tick(2);
    clrn = 1'b1;
    tick(2);
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    chk("t6_ready", {31'd0, ready}, 32'd1);
    chk("t6_data", {24'd0, data}, 32'h5A);
    pop1();
    chk("t6_empty", {31'd0, ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
